// File: rtl/i2s_sched_pkg.sv
// Shared constants and helpers for the I2S per-frame sample scheduler.
package i2s_sched_pkg;
  localparam int SAMPLE_W  = 16;
  localparam int DEF_DEPTH = 4;

  localparam logic [1:0] MODE_SRC0 = 2'b00;
  localparam logic [1:0] MODE_SRC1 = 2'b01;
  localparam logic [1:0] MODE_MIX  = 2'b10;
  localparam logic [1:0] MODE_MUTE = 2'b11;

  // Stereo pair as stored in the FIFOs: L in the upper half, R in the lower.
  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } sample_t;

  // Two's-complement add with clamping to the 16-bit range.
  function automatic logic [SAMPLE_W-1:0] sat16(input logic [SAMPLE_W-1:0] a,
                                                input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] s;
    s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    case (s[SAMPLE_W:SAMPLE_W-1])
      2'b01:   return {1'b0, {(SAMPLE_W-1){1'b1}}};
      2'b10:   return {1'b1, {(SAMPLE_W-1){1'b0}}};
      default: return s[SAMPLE_W-1:0];
    endcase
  endfunction
endpackage

// File: rtl/i2s_sample_fifo.sv
// Per-source sample FIFO; pushes on full and pops on empty are ignored.
module i2s_sample_fifo
  import i2s_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = 2 * SAMPLE_W
) (
  input  logic         w_clk,
  input  logic         i_rst_x,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_head  = mem_q[rd_q];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge w_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge w_clk) begin
    if (do_push) mem_q[wr_q] <= i_data;
  end
endmodule

// File: rtl/i2s_sample_scheduler.sv
// Frame-latched L/R sample scheduler for the I2S encoder (bit-clock domain).
// Define I2S_SCHED_MIX_EN to enable saturating mix in mode 10.
module i2s_sample_scheduler
  import i2s_sched_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int UCNT_W = 8
) (
  input  logic              w_clk,
  input  logic              i_rst_x,
  input  logic              i_latch,
  input  logic [1:0]        i_mode,
  input  logic              i_s0_valid,
  input  logic [15:0]       i_s0_l,
  input  logic [15:0]       i_s0_r,
  output logic              o_s0_ready,
  input  logic              i_s1_valid,
  input  logic [15:0]       i_s1_l,
  input  logic [15:0]       i_s1_r,
  output logic              o_s1_ready,
  output logic [15:0]       o_data_l,
  output logic [15:0]       o_data_r,
  output logic [1:0]        o_mode,
  output logic              o_underrun,
  output logic [UCNT_W-1:0] o_underrun_cnt
);
  sample_t     h0, h1, samp_d, data_q;
  logic        f0, f1, e0, e1, urun_d, urun_q;
  logic [1:0]  mode_d, mode_q;
  logic [UCNT_W-1:0] ucnt_q;

  // Both FIFOs pop on every frame edge to keep the sources rate-locked.
  i2s_sample_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .w_clk(w_clk), .i_rst_x(i_rst_x),
    .i_push(i_s0_valid && o_s0_ready), .i_pop(i_latch),
    .i_data({i_s0_l, i_s0_r}), .o_head(h0), .o_full(f0), .o_empty(e0)
  );
  i2s_sample_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .w_clk(w_clk), .i_rst_x(i_rst_x),
    .i_push(i_s1_valid && o_s1_ready), .i_pop(i_latch),
    .i_data({i_s1_l, i_s1_r}), .o_head(h1), .o_full(f1), .o_empty(e1)
  );

  assign o_s0_ready = !f0;
  assign o_s1_ready = !f1;

  always_comb begin
    mode_d = i_mode;
`ifndef I2S_SCHED_MIX_EN
    if (i_mode == MODE_MIX) mode_d = MODE_SRC0;
`endif
    samp_d = '0;
    urun_d = 1'b0;
    case (mode_d)
      MODE_SRC0: begin urun_d = e0; if (!e0) samp_d = h0; end
      MODE_SRC1: begin urun_d = e1; if (!e1) samp_d = h1; end
`ifdef I2S_SCHED_MIX_EN
      MODE_MIX: begin
        samp_d.l = sat16(e0 ? '0 : h0.l, e1 ? '0 : h1.l);
        samp_d.r = sat16(e0 ? '0 : h0.r, e1 ? '0 : h1.r);
        urun_d   = e0 || e1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge w_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      data_q <= '0;
      mode_q <= MODE_SRC0;
      urun_q <= 1'b0;
      ucnt_q <= '0;
    end else begin
      urun_q <= i_latch && urun_d;
      if (i_latch) begin
        data_q <= samp_d;
        mode_q <= mode_d;
        if (urun_d && ucnt_q != '1) ucnt_q <= ucnt_q + 1'b1;
      end
    end
  end

  assign o_data_l       = data_q.l;
  assign o_data_r       = data_q.r;
  assign o_mode         = mode_q;
  assign o_underrun     = urun_q;
  assign o_underrun_cnt = ucnt_q;
endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Scoreboard bench for i2s_sample_scheduler; follows I2S_SCHED_MIX_EN if defined.
module tb_i2s_sample_scheduler;
  localparam int DEPTH = 4;

  logic        w_clk = 1'b0;
  logic        i_rst_x = 1'b0;
  logic        i_latch = 1'b0;
  logic [1:0]  i_mode = 2'b00;
  logic        i_s0_valid = 1'b0, i_s1_valid = 1'b0;
  logic [15:0] i_s0_l = '0, i_s0_r = '0, i_s1_l = '0, i_s1_r = '0;
  logic        o_s0_ready, o_s1_ready, o_underrun;
  logic [15:0] o_data_l, o_data_r;
  logic [1:0]  o_mode;
  logic [7:0]  o_underrun_cnt;

  i2s_sample_scheduler #(.DEPTH(DEPTH), .UCNT_W(8)) dut (
    .w_clk(w_clk), .i_rst_x(i_rst_x), .i_latch(i_latch), .i_mode(i_mode),
    .i_s0_valid(i_s0_valid), .i_s0_l(i_s0_l), .i_s0_r(i_s0_r), .o_s0_ready(o_s0_ready),
    .i_s1_valid(i_s1_valid), .i_s1_l(i_s1_l), .i_s1_r(i_s1_r), .o_s1_ready(o_s1_ready),
    .o_data_l(o_data_l), .o_data_r(o_data_r), .o_mode(o_mode),
    .o_underrun(o_underrun), .o_underrun_cnt(o_underrun_cnt)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [15:0] l, r;
    logic [1:0]  m;
    logic        u;
    logic [7:0]  c;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  logic [31:0] q0[$], q1[$];
  int          ucnt = 0;
  int          checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic push(input int src, input logic [15:0] l, input logic [15:0] r);
    if (src == 0) begin
      i_s0_valid = 1'b1; i_s0_l = l; i_s0_r = r;
      chk("s0_ready", o_s0_ready, q0.size() < DEPTH);
      if (q0.size() < DEPTH) q0.push_back({l, r});
    end else begin
      i_s1_valid = 1'b1; i_s1_l = l; i_s1_r = r;
      chk("s1_ready", o_s1_ready, q1.size() < DEPTH);
      if (q1.size() < DEPTH) q1.push_back({l, r});
    end
    @(negedge w_clk);
    i_s0_valid = 1'b0; i_s1_valid = 1'b0;
  endtask

  // One latch cycle, optionally with a simultaneous src0 push.
  task automatic frame(input logic [1:0] m, input bit p0 = 0,
                       input logic [15:0] pl = 16'h0, input logic [15:0] pr = 16'h0);
    exp_t        e;
    logic        e0, e1, rdy;
    logic [31:0] h0, h1;
    logic [1:0]  em;
    i_mode = m; i_latch = 1'b1;
    rdy = q0.size() < DEPTH;
    if (p0) begin
      i_s0_valid = 1'b1; i_s0_l = pl; i_s0_r = pr;
      chk("s0_ready_f", o_s0_ready, rdy);
    end
    e0 = (q0.size() == 0); h0 = e0 ? 32'h0 : q0.pop_front();
    e1 = (q1.size() == 0); h1 = e1 ? 32'h0 : q1.pop_front();
    em = m;
`ifndef I2S_SCHED_MIX_EN
    if (m == 2'b10) em = 2'b00;
`endif
    e.m = em;
    case (em)
      2'b00: begin e.l = h0[31:16]; e.r = h0[15:0]; e.u = e0; end
      2'b01: begin e.l = h1[31:16]; e.r = h1[15:0]; e.u = e1; end
      2'b10: begin
        e.l = sat(h0[31:16], h1[31:16]); e.r = sat(h0[15:0], h1[15:0]); e.u = e0 | e1;
      end
      default: begin e.l = 16'h0; e.r = 16'h0; e.u = 1'b0; end
    endcase
    if (p0 && rdy) q0.push_back({pl, pr});
    if (e.u && ucnt != 255) ucnt++;
    e.c = 8'(ucnt);
    sb.push_back(e);
    @(negedge w_clk);
    i_latch = 1'b0; i_s0_valid = 1'b0;
    e = sb.pop_front();
    chk("data_l", o_data_l, e.l);
    chk("data_r", o_data_r, e.r);
    chk("mode", o_mode, e.m);
    chk("underrun", o_underrun, e.u);
    chk("ucnt", o_underrun_cnt, e.c);
    last = e;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_data_l", o_data_l, 0); chk("rst_data_r", o_data_r, 0);
    chk("rst_mode", o_mode, 0); chk("rst_urun", o_underrun, 0);
    chk("rst_ucnt", o_underrun_cnt, 0);
    chk("rst_rdy0", o_s0_ready, 1); chk("rst_rdy1", o_s1_ready, 1);
    @(negedge w_clk); i_rst_x = 1'b1;
    @(negedge w_clk);

    // Basic src0 transfer, then src1 underrun that still pops src0
    push(0, 16'h1234, 16'habcd);
    frame(2'b00);
    push(0, 16'h1111, 16'h2222);
    frame(2'b01);
    frame(2'b00);

    // Fill src0, overflow attempt dropped, drain in order
    for (int i = 1; i <= 5; i++) push(0, 16'(i), 16'(16'h100 + i));
    chk("full_ready", o_s0_ready, 0);
    for (int i = 0; i < 5; i++) frame(2'b00);

    // Mix (or src0 fallback when the mix feature is absent)
    push(0, 16'h7000, 16'h9000); push(1, 16'h2000, 16'h9000);
    frame(2'b10);
    push(0, 16'h0100, 16'hff00); push(1, 16'hff00, 16'h0100);
    frame(2'b10);
    push(0, 16'h0005, 16'hfffb);
    frame(2'b10);
    frame(2'b11);

    // Push and pop on the same edge into an empty FIFO: stored, not bypassed
    frame(2'b00, 1, 16'h4444, 16'h5555);
    frame(2'b00);

    // Mid-frame mode change must not disturb outputs
    push(0, 16'h3c3c, 16'hc3c3);
    frame(2'b00);
    i_mode = 2'b01;
    push(1, 16'h7777, 16'h8888);
    for (int i = 0; i < 4; i++) begin
      @(negedge w_clk);
      chk("hold_l", o_data_l, last.l); chk("hold_r", o_data_r, last.r);
      chk("hold_mode", o_mode, last.m);
    end
    frame(2'b01);

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      frame(2'b01);
      if (i < 3) begin
        @(negedge w_clk);
        chk("urun_clr", o_underrun, 0);
      end
    end

    // Asynchronous reset mid-frame
    push(0, 16'h5555, 16'haaaa); push(1, 16'h1, 16'h2);
    frame(2'b00);
    repeat (3) @(negedge w_clk);
    #2 i_rst_x = 1'b0;
    #1;
    chk("arst_data_l", o_data_l, 0); chk("arst_data_r", o_data_r, 0);
    chk("arst_mode", o_mode, 0); chk("arst_urun", o_underrun, 0);
    chk("arst_ucnt", o_underrun_cnt, 0);
    chk("arst_rdy0", o_s0_ready, 1); chk("arst_rdy1", o_s1_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_sample_scheduler.md
# i2s_sample_scheduler

Per-frame sample scheduler that feeds the 16-bit L/R inputs of the I2S encoder. Two producer sources push stereo samples over valid/ready into per-source FIFOs. On each encoder frame-latch strobe the block pops the FIFOs and registers the selected (or mixed) sample pair. It also reports underruns. It runs entirely in the encoder's bit-clock domain.

## Interface

Parameters:
- DEPTH, 4 — entries per source FIFO; power of two, minimum 2.
- UCNT_W, 8 — underrun counter width.

Ports:
- w_clk  in  1  — clock; the encoder's internal bit clock (inverted BCLK).
- i_rst_x  in  1  — reset, asynchronous, active-low.
- i_latch  in  1  — frame strobe from the encoder; high for exactly one w_clk cycle per 64-cycle frame.
- i_mode  in  2  — source select: 00 = src0, 01 = src1, 10 = mix, 11 = mute.
- i_s0_valid  in  1  — src0 sample valid.
- i_s0_l, i_s0_r  in  16  — src0 sample pair, two's complement.
- o_s0_ready  out  1  — src0 FIFO not full.
- i_s1_valid, i_s1_l, i_s1_r, o_s1_ready — same as src0, for src1.
- o_data_l, o_data_r  out  16  — sample pair to the encoder.
- o_mode  out  2  — mode in effect for the current frame.
- o_underrun  out  1  — one-cycle pulse on an underrun frame.
- o_underrun_cnt  out  UCNT_W  — saturating underrun count.

## Operation

- Push: on a w_clk edge with sN_valid && sN_ready, the pair is written to FIFO N. Ready = !full (combinational from FIFO state).
- Frame edge: every w_clk edge where i_latch = 1.
  - i_mode is sampled into o_mode.
  - Every non-empty FIFO pops one entry, whether or not it is selected. This keeps both sources rate-locked and prevents stale build-up.
  - o_data is loaded according to the sampled mode:
    - 00 / 01: head of FIFO 0 / 1. If that FIFO is empty, load 0 and flag underrun.
    - 10: per channel, sat16(sext17(s0) + sext17(s1)). Sum exceeding +32767 → 0x7FFF; below −32768 → 0x8000. An empty FIFO contributes 0. Either FIFO empty flags underrun.
    - 11: load 0. No underrun is flagged.
  - Underrun: o_underrun high for the following cycle. o_underrun_cnt increments and holds at all-ones.
- Outside frame edges, o_data, o_mode and FIFO read pointers hold.
- A push and a pop on the same edge are both honoured. On a full FIFO, ready is low, so only the pop occurs. On an empty FIFO, the pop is an underrun and the pushed word is stored; it is not bypassed.
- Reset, asynchronous and valid at any point including mid-frame:
  - FIFOs are emptied (both ready = 1).
  - o_data_l = o_data_r = 0, o_mode = 00, o_underrun = 0, o_underrun_cnt = 0.

## Timing

- Latency from latch to data is one edge. The encoder asserts latch at its count 0; new o_data is visible from count 1 and holds for 64 cycles. This covers the encoder's shift window at counts 1–48.
- Push to earliest availability: a word pushed at edge k is poppable at any frame edge after k.
- A mode change takes effect only at the next frame edge; there is no mid-frame switching.
- FIFO occupancy is a (log2(DEPTH)+1)-bit count. Pointers wrap modulo DEPTH.

## Configuration

- I2S_SCHED_MIX_EN defined: mode 10 mixes as described above.
- Not defined: the adder and saturation logic are omitted. Mode 10 behaves exactly as mode 00, and o_mode reports 00.

## Structure

- Package i2s_sched_pkg holds:
  - mode constants MODE_SRC0, MODE_SRC1, MODE_MIX, MODE_MUTE;
  - the sample width constant (16);
  - the default DEPTH.
- Sub-module i2s_sample_fifo: one instance per source, 32-bit wide (L in [31:16], R in [15:0]).
  - Ports: push, pop, data in, head out, full, empty.
  - Pop on empty is ignored.

## Test plan

- Reset, then push src0 (0x1234, 0xABCD); mode 00; pulse latch → next cycle o_data = 0x1234/0xABCD, o_underrun = 0, FIFO empty.
- Mode 01 with src1 empty, latch → o_data = 0/0, o_underrun pulses, cnt = 1; src0 FIFO is also popped.
- Push 4 words to src0 with no latch → o_s0_ready = 0 after the 4th. Push attempt 5 is dropped. Four latches return words 1–4 in order.
- Mix (macro on): src0 = 0x7000, src1 = 0x2000 → 0x7FFF. src0 = 0x9000, src1 = 0x9000 → 0x8000. 0x0100 + 0xFF00 → 0x0000.
- Change i_mode mid-frame → o_data and o_mode are unchanged until the next latch. With the macro off, mode 10 → src0 data, o_mode = 00.
- 300 underrun frames → cnt saturates at 0xFF. Assert i_rst_x low mid-frame → all outputs at reset values immediately.
